encoder_8x3_scan: RTL and testbench



---
 rtl/encoder_8x3_scan.sv | 102 ++++++++++
 tb/tb_encoder_8x3_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/encoder_8x3_scan.sv
// Sequential 8-to-3 encoder: latches a line vector, then emits the index of each
// set line, highest first, one per enabled clock, followed by a done pulse.
module encoder_8x3_scan (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic [7:0] d,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic       zero,
    output logic [3:0] count
);

    localparam int unsigned LINES = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state, state_nxt;
    logic [LINES-1:0]   pend, pend_nxt, pend_clr;
    logic [IDX_W-1:0]   idx, idx_nxt, hi;
    logic [CNT_W-1:0]   count_nxt;
    logic               valid_nxt, busy_nxt, done_nxt, zero_nxt;

    assign {a, b, c} = idx;

    // Highest pending line; ascending loop lets the top set bit win.
    always_comb begin
        hi = '0;
        for (int i = 0; i < LINES; i++) begin
            if (pend[i]) hi = IDX_W'(i);
        end
        pend_clr = pend & ~(LINES'(1) << hi);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
            idx   <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            zero  <= 1'b0;
            count <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            idx   <= idx_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            zero  <= zero_nxt;
            count <= count_nxt;
        end
    end

    // With en low everything holds except the valid/done pulses, which drop.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        idx_nxt   = idx;
        valid_nxt = 1'b0;
        done_nxt  = 1'b0;
        busy_nxt  = busy;
        zero_nxt  = zero;
        count_nxt = count;
        if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pend_nxt  = d;
                        count_nxt = '0;
                        busy_nxt  = 1'b1;
                        zero_nxt  = (d == '0);
                        state_nxt = (d == '0) ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    idx_nxt   = hi;
                    valid_nxt = 1'b1;
                    count_nxt = count + CNT_W'(1);
                    pend_nxt  = pend_clr;
                    if (pend_clr == '0) state_nxt = DONE;
                end
                DONE: begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_8x3_scan.sv
// Bench for encoder_8x3_scan: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_encoder_8x3_scan;

    logic       clk = 1'b0;
    logic       rst, en, start;
    logic [7:0] d;
    logic       a, b, c, valid, busy, done, zero;
    logic [3:0] count;

    encoder_8x3_scan dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .d(d),
        .a(a), .b(b), .c(c), .valid(valid), .busy(busy), .done(done),
        .zero(zero), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a scan is a queue of indices to emit, then one done edge.
    bit          m_act = 0;
    int unsigned q[$];
    int          m_idx = 0, m_cnt = 0;
    bit          m_valid = 0, m_busy = 0, m_done = 0, m_zero = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_act = 0; q.delete();
            m_idx = 0; m_cnt = 0;
            m_valid = 0; m_busy = 0; m_done = 0; m_zero = 0;
        end else if (!en) begin
            m_valid = 0; m_done = 0;
        end else begin
            m_valid = 0; m_done = 0;
            if (!m_act) begin
                if (start) begin
                    m_act = 1;
                    q.delete();
                    for (int i = 7; i >= 0; i--) if (d[i]) q.push_back(i);
                    m_cnt  = 0;
                    m_busy = 1;
                    m_zero = (d == 8'h00);
                end
            end else if (q.size() != 0) begin
                m_idx   = int'(q.pop_front());
                m_valid = 1;
                m_cnt++;
            end else begin
                m_done = 1;
                m_busy = 0;
                m_act  = 0;
            end
        end
    end

    function automatic logic [10:0] pack(bit v, bit bz, bit dn, bit zr, int ix, int cn);
        return {v, bz, dn, zr, 3'(ix), 4'(cn)};
    endfunction

    bit          chk = 0;
    int          pin_req = 0, pin_ack = 0;
    logic [10:0] pin_exp;
    string       pin_name;

    // Single compare process: model every cycle, plus any pending literal pin.
    always @(negedge clk) begin
        logic [10:0] act, exp;
        act = {valid, busy, done, zero, a, b, c, count};
        if (chk) begin
            exp = pack(m_valid, m_busy, m_done, m_zero, m_idx, m_cnt);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL model t=%0t {v,busy,done,zero,abc,count} got=%b want=%b", $time, act, exp);
            end
        end
        if (pin_req != pin_ack) begin
            total++;
            if (act !== pin_exp) begin
                bad++;
                $display("FAIL %s {v,busy,done,zero,abc,count} got=%b want=%b", pin_name, act, pin_exp);
            end
            pin_ack = pin_req;
        end
    end

    task automatic tick(bit r, bit e, bit s, logic [7:0] dv);
        rst = r; en = e; start = s; d = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic pin(string nm, bit v, bit bz, bit dn, bit zr, int ix, int cn);
        pin_name = nm;
        pin_exp  = pack(v, bz, dn, zr, ix, cn);
        pin_req++;
    endtask

    initial begin
        tick(1, 0, 0, 8'h00);
        chk = 1;
        pin("reset", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 0, 8'h00);
            pin("idle", 0, 0, 0, 0, 0, 0);
        end

        // 1001_0100 -> 7,4,2
        tick(0, 1, 1, 8'b1001_0100); pin("s94_start", 0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 8'h00);        pin("s94_i7", 1, 1, 0, 0, 7, 1);
        tick(0, 1, 0, 8'h00);        pin("s94_i4", 1, 1, 0, 0, 4, 2);
        tick(0, 1, 0, 8'h00);        pin("s94_i2", 1, 1, 0, 0, 2, 3);
        tick(0, 1, 0, 8'h00);        pin("s94_done", 0, 0, 1, 0, 2, 3);
        tick(0, 1, 0, 8'h00);        pin("s94_hold", 0, 0, 0, 0, 2, 3);

        // empty vector
        tick(0, 1, 1, 8'h00);        pin("z_start", 0, 1, 0, 1, 2, 0);
        tick(0, 1, 0, 8'h00);        pin("z_done", 0, 0, 1, 1, 2, 0);
        tick(0, 1, 0, 8'h00);        pin("z_hold", 0, 0, 0, 1, 2, 0);

        // all lines set
        tick(0, 1, 1, 8'hFF);        pin("ff_start", 0, 1, 0, 0, 2, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 0, 8'h00);    pin("ff_idx", 1, 1, 0, 0, 7 - i, i + 1);
        end
        tick(0, 1, 0, 8'h00);        pin("ff_done", 0, 0, 1, 0, 0, 8);
        tick(0, 1, 0, 8'h00);        pin("ff_hold", 0, 0, 0, 0, 0, 8);

        // pause mid-scan, with ignored starts
        tick(0, 1, 1, 8'b0000_1011); pin("p_start", 0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 8'h00);        pin("p_i3", 1, 1, 0, 0, 3, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 8'h80);    pin("p_pause", 0, 1, 0, 0, 3, 1);
        end
        tick(0, 1, 1, 8'h80);        pin("p_i1", 1, 1, 0, 0, 1, 2);
        tick(0, 1, 1, 8'h80);        pin("p_i0", 1, 1, 0, 0, 0, 3);
        tick(0, 1, 0, 8'h00);        pin("p_done", 0, 0, 1, 0, 0, 3);
        tick(0, 1, 0, 8'h00);        pin("p_hold", 0, 0, 0, 0, 0, 3);

        // reset mid-scan, then a fresh single-line scan
        tick(0, 1, 1, 8'hF0);        pin("r_start", 0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 8'h00);        pin("r_i7", 1, 1, 0, 0, 7, 1);
        tick(0, 1, 0, 8'h00);        pin("r_i6", 1, 1, 0, 0, 6, 2);
        tick(1, 1, 0, 8'h00);        pin("r_abort", 0, 0, 0, 0, 0, 0);
        tick(0, 1, 1, 8'h01);        pin("r_restart", 0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 8'h00);        pin("r_i0", 1, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 8'h00);        pin("r_done", 0, 0, 1, 0, 0, 1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] dv;
            case ($urandom_range(0, 7))
                0:       dv = 8'h00;
                1:       dv = 8'hFF;
                2:       dv = 8'(1 << $urandom_range(0, 7));
                default: dv = 8'($urandom);
            endcase
            tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0), dv);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
